// File: rtl/ahb2apb_pkg.sv
// Shared state encoding and AHB bus codes for the AHB-to-APB bridge.
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Width of the slave slot field carved out of HADDR.
    localparam int SLOT_W = 4;

    function automatic logic is_active_trans(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb2apb_decode.sv
// Slot decoder for the AHB-to-APB bridge: one-hot PSEL enable for the slot
// being launched, and a PRDATA lane mux for the slot being completed.
module ahb2apb_decode
    import ahb2apb_pkg::*;
#(
    parameter int NUM_SLV = 4
) (
    input  logic [SLOT_W-1:0]     sel_slot_i,
    input  logic [SLOT_W-1:0]     rd_slot_i,
    input  logic [32*NUM_SLV-1:0] prdata_bus_i,
    output logic [NUM_SLV-1:0]    sel_onehot_o,
    output logic                  sel_valid_o,
    output logic [31:0]           rdata_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_sel
            assign sel_onehot_o[gi] = (sel_slot_i == SLOT_W'(gi));
        end
    endgenerate

    // Slots beyond the populated slaves are unmapped and produce an ERROR.
    assign sel_valid_o = ({{(32-SLOT_W){1'b0}}, sel_slot_i} < 32'(NUM_SLV));

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (rd_slot_i == SLOT_W'(k)) begin
                rdata_o = prdata_bus_i[k*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// Non-posted AHB-to-APB bridge: each accepted AHB transfer becomes one APB access.
// Define AHB2APB_PREADY_EN to add PREADY/PSLVERR wait-state and error support.
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 12
) (
    input  logic                  PCLK,
    input  logic                  PRST_N,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic [NUM_SLV-1:0]    PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
`ifdef AHB2APB_PREADY_EN
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR,
`endif
    input  logic [32*NUM_SLV-1:0] PRDATA_BUS
);

    state_e              state_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                hreadyout_q;
    logic [1:0]          hresp_q;
    logic [31:0]         hrdata_q;
    logic [NUM_SLV-1:0]  psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [31:0]         paddr_q;
    logic [31:0]         pwdata_q;

    logic [SLOT_W-1:0]   haddr_slot;
    logic [SLOT_W-1:0]   sel_slot;
    logic                accept;
    logic [NUM_SLV-1:0]  sel_onehot;
    logic                sel_valid;
    logic [31:0]         lane_rdata;
    logic                pready_sel;
    logic                pslverr_sel;

    assign haddr_slot = HADDR[SLV_SEL_LSB+SLOT_W-1:SLV_SEL_LSB];
    assign accept     = HSEL & HREADY & is_active_trans(HTRANS);

    // A read launches PSEL straight from the address phase; a write launches it
    // from the registered slot once the data phase has been captured.
    assign sel_slot   = (state_q == ST_WDATA) ? slot_q : haddr_slot;

    ahb2apb_decode #(
        .NUM_SLV (NUM_SLV)
    ) u_decode (
        .sel_slot_i   (sel_slot),
        .rd_slot_i    (slot_q),
        .prdata_bus_i (PRDATA_BUS),
        .sel_onehot_o (sel_onehot),
        .sel_valid_o  (sel_valid),
        .rdata_o      (lane_rdata)
    );

`ifdef AHB2APB_PREADY_EN
    logic [NUM_SLV-1:0] slot_hit;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_hit
            assign slot_hit[gi] = (slot_q == SLOT_W'(gi));
        end
    endgenerate
    assign pready_sel  = |(PREADY & slot_hit);
    assign pslverr_sel = |(PSLVERR & slot_hit);
`else
    assign pready_sel  = 1'b1;
    assign pslverr_sel = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                    if (accept) begin
                        paddr_q     <= HADDR;
                        pwrite_q    <= HWRITE;
                        slot_q      <= haddr_slot;
                        hreadyout_q <= 1'b0;
                        if (!sel_valid) begin
                            state_q <= ST_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end else if (HWRITE) begin
                            state_q <= ST_WDATA;
                        end else begin
                            state_q <= ST_SETUP;
                            psel_q  <= sel_onehot;
                        end
                    end
                end
                ST_WDATA: begin
                    pwdata_q <= HWDATA;
                    psel_q   <= sel_onehot;
                    state_q  <= ST_SETUP;
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_sel) begin
                        if (!pwrite_q) begin
                            hrdata_q <= lane_rdata;
                        end
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (pslverr_sel) begin
                            state_q <= ST_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end else begin
                            state_q     <= ST_DONE;
                            hreadyout_q <= 1'b1;
                        end
                    end
                end
                ST_ERR1: begin
                    // Second cycle of the two-cycle AHB ERROR response.
                    hreadyout_q <= 1'b1;
                    state_q     <= ST_ERR2;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: directed and randomized AHB transfers
// checked cycle by cycle against a transfer-level model of the bridge.
module tb_ahb2apb_bridge;
    import ahb2apb_pkg::*;

    localparam int NUM_SLV = 4;

    logic                  PCLK = 1'b0;
    logic                  PRST_N = 1'b0;
    logic                  HSEL = 1'b0;
    logic [1:0]            HTRANS = 2'b00;
    logic                  HWRITE = 1'b0;
    logic [31:0]           HADDR = '0;
    logic [31:0]           HWDATA = '0;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [31:0]           HRDATA;
    logic [NUM_SLV-1:0]    PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic [32*NUM_SLV-1:0] PRDATA_BUS;
`ifdef AHB2APB_PREADY_EN
    logic [NUM_SLV-1:0]    PREADY = '1;
    logic [NUM_SLV-1:0]    PSLVERR = '0;
`endif

    logic                  hready_block = 1'b0;
    logic [31:0]           lane_val [NUM_SLV];

    // Model state: last completed read data and last written data.
    logic [31:0]           mdl_rdata = '0;
    logic [31:0]           mdl_wdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;

    always #5 PCLK = ~PCLK;

    // Another slave on the bus may stretch HREADY low.
    assign HREADY = HREADYOUT & ~hready_block;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_lane
            assign PRDATA_BUS[gi*32 +: 32] = lane_val[gi];
        end
    endgenerate

    ahb2apb_bridge #(
        .NUM_SLV     (NUM_SLV),
        .SLV_SEL_LSB (12)
    ) dut (
        .PCLK       (PCLK),
        .PRST_N     (PRST_N),
        .HSEL       (HSEL),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
`ifdef AHB2APB_PREADY_EN
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
`endif
        .PRDATA_BUS (PRDATA_BUS)
    );

    task automatic randomize_lanes();
        for (int k = 0; k < NUM_SLV; k++) lane_val[k] = $urandom;
    endtask

    // One complete AHB transfer; the next call may start in this one's final
    // ready cycle, which gives back-to-back traffic for free.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int                 slot;
        int                 exp_wait;
        int                 waits;
        bit                 mapped;
        logic [NUM_SLV-1:0] one_hot;
        logic [NUM_SLV-1:0] exp_sel;
        logic [NUM_SLV-1:0] exp_psel;
        logic               exp_pen;
        logic [1:0]         exp_resp;

        slot     = int'(addr[15:12]);
        mapped   = (slot < NUM_SLV);
        exp_wait = !mapped ? 1 : (wr ? 3 : 2);
        one_hot  = 1;
        exp_sel  = mapped ? (one_hot << slot) : '0;
        exp_resp = mapped ? HRESP_OKAY : HRESP_ERROR;
        if (mapped && !wr) mdl_rdata = lane_val[slot];
        if (mapped && wr)  mdl_wdata = wdata;

        HSEL   = 1'b1;
        HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
        HWRITE = wr;
        HADDR  = addr;
        @(posedge PCLK); #1;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = $urandom;
        HWDATA = wdata;

        waits = 0;
        while (HREADYOUT !== 1'b1 && waits < 12) begin
            exp_pen  = mapped && (waits == exp_wait - 1);
            exp_psel = (mapped && waits >= exp_wait - 2) ? exp_sel : '0;
            n_cmp++;
            if ({PSEL, PENABLE, HRESP} !== {exp_psel, exp_pen, exp_resp}) begin
                n_bad++;
                $display("FAIL wait_cycle xfer%0d cyc%0d: psel/pen/hresp got %b/%b/%b want %b/%b/%b",
                         n_xfer, waits, PSEL, PENABLE, HRESP, exp_psel, exp_pen, exp_resp);
            end
            if (exp_pen) begin
                n_cmp++;
                if ({PADDR, PWRITE, PWDATA} !== {addr, wr, mdl_wdata}) begin
                    n_bad++;
                    $display("FAIL access_bus xfer%0d: paddr/pwrite/pwdata got %h/%b/%h want %h/%b/%h",
                             n_xfer, PADDR, PWRITE, PWDATA, addr, wr, mdl_wdata);
                end
            end
            waits++;
            @(posedge PCLK); #1;
        end

        n_cmp++;
        if (waits != exp_wait) begin
            n_bad++;
            $display("FAIL wait_states xfer%0d: got %0d want %0d", n_xfer, waits, exp_wait);
        end
        n_cmp++;
        if ({HREADYOUT, HRESP, PSEL, PENABLE} !== {1'b1, exp_resp, {NUM_SLV{1'b0}}, 1'b0}) begin
            n_bad++;
            $display("FAIL final_resp xfer%0d: hreadyout/hresp/psel/pen got %b/%b/%b/%b want 1/%b/0/0",
                     n_xfer, HREADYOUT, HRESP, PSEL, PENABLE, exp_resp);
        end
        n_cmp++;
        if (HRDATA !== mdl_rdata) begin
            n_bad++;
            $display("FAIL hrdata xfer%0d: got %h want %h", n_xfer, HRDATA, mdl_rdata);
        end
        n_cmp++;
        if ({PADDR, PWRITE, PWDATA} !== {addr, wr, mdl_wdata}) begin
            n_bad++;
            $display("FAIL held_bus xfer%0d: paddr/pwrite/pwdata got %h/%b/%h want %h/%b/%h",
                     n_xfer, PADDR, PWRITE, PWDATA, addr, wr, mdl_wdata);
        end
        $display("xfer %0d %s addr=%h slot=%0d waits=%0d hresp=%b hrdata=%h",
                 n_xfer, wr ? "WR" : "RD", addr, slot, waits, HRESP, HRDATA);
        n_xfer++;
    endtask

    // Cycles with no accepted transfer must be zero-wait OKAY with no APB activity.
    task automatic test_idle(input int n);
        int mode;
        for (int i = 0; i < n; i++) begin
            mode   = $urandom_range(0, 2);
            HWRITE = 1'($urandom_range(0, 1));
            HADDR  = $urandom;
            case (mode)
                0: begin HSEL = 1'b0; HTRANS = 2'($urandom_range(0, 3)); end
                1: begin HSEL = 1'b1; HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_BUSY : HTRANS_IDLE; end
                default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; hready_block = 1'b1; end
            endcase
            @(posedge PCLK); #1;
            hready_block = 1'b0;
            HSEL   = 1'b0;
            HTRANS = HTRANS_IDLE;
            n_cmp++;
            if ({HREADYOUT, HRESP, PSEL, PENABLE} !== {1'b1, HRESP_OKAY, {NUM_SLV{1'b0}}, 1'b0}) begin
                n_bad++;
                $display("FAIL idle_cycle mode%0d: hreadyout/hresp/psel/pen got %b/%b/%b/%b want 1/00/0/0",
                         mode, HREADYOUT, HRESP, PSEL, PENABLE);
            end
        end
    endtask

    task automatic test_reset();
        PRST_N = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        n_cmp++;
        if ({HREADYOUT, HRESP, HRDATA, PSEL, PENABLE} !== {1'b1, 2'b00, 32'h0, {NUM_SLV{1'b0}}, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_ahb: hreadyout/hresp/hrdata/psel/pen got %b/%b/%h/%b/%b want 1/00/0/0/0",
                     HREADYOUT, HRESP, HRDATA, PSEL, PENABLE);
        end
        n_cmp++;
        if ({PWRITE, PADDR, PWDATA} !== {1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_apb: pwrite/paddr/pwdata got %b/%h/%h want 0/0/0", PWRITE, PADDR, PWDATA);
        end
        PRST_N = 1'b1;
        mdl_rdata = '0;
        mdl_wdata = '0;
        test_idle(2);
    endtask

    task automatic test_single_write();
        randomize_lanes();
        do_xfer(1'b1, 32'h0000_1018, 32'hA5A5_0F0F);
        test_idle(1);
    endtask

    task automatic test_single_read();
        randomize_lanes();
        lane_val[0] = 32'h1234_5678;
        do_xfer(1'b0, 32'h0000_0018, $urandom);
        test_idle(1);
    endtask

    task automatic test_back_to_back();
        randomize_lanes();
        do_xfer(1'b0, 32'h0000_0004, $urandom);
        do_xfer(1'b0, 32'h0000_2008, $urandom);
        do_xfer(1'b1, 32'h0000_3010, $urandom);
        do_xfer(1'b0, 32'h0000_1000, $urandom);
        test_idle(1);
    endtask

    task automatic test_unmapped();
        randomize_lanes();
        do_xfer(1'b0, 32'h0000_7000, $urandom);
        do_xfer(1'b1, 32'h0000_F004, $urandom);
        do_xfer(1'b0, 32'h0000_2000, $urandom);
        test_idle(1);
    endtask

    task automatic test_reset_mid();
        int waits;
        randomize_lanes();
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b0;
        HADDR  = 32'h0000_3010;
        @(posedge PCLK); #1;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        waits  = 0;
        while (PENABLE !== 1'b1 && waits < 8) begin
            @(posedge PCLK); #1;
            waits++;
        end
        n_cmp++;
        if ({PSEL, PENABLE} !== {4'b1000, 1'b1}) begin
            n_bad++;
            $display("FAIL reach_access: psel/pen got %b/%b want 1000/1", PSEL, PENABLE);
        end
        PRST_N = 1'b0;
        #1;
        n_cmp++;
        if ({PSEL, PENABLE, HREADYOUT} !== {{NUM_SLV{1'b0}}, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: psel/pen/hreadyout got %b/%b/%b want 0/0/1", PSEL, PENABLE, HREADYOUT);
        end
        @(posedge PCLK); #1;
        PRST_N = 1'b1;
        mdl_rdata = '0;
        mdl_wdata = '0;
        test_idle(1);
        n_cmp++;
        if (HRDATA !== 32'h0) begin
            n_bad++;
            $display("FAIL abandoned_read: hrdata got %h want 00000000", HRDATA);
        end
        do_xfer(1'b0, 32'h0000_3010, $urandom);
        test_idle(1);
    endtask

`ifdef AHB2APB_PREADY_EN
    task automatic test_pready();
        int cyc;
        int pen;
        int err1;
        randomize_lanes();
        PREADY  = 4'b1101;
        PSLVERR = 4'b0000;
        HSEL    = 1'b1;
        HTRANS  = HTRANS_NONSEQ;
        HWRITE  = 1'b0;
        HADDR   = 32'h0000_1004;
        @(posedge PCLK); #1;
        HSEL    = 1'b0;
        HTRANS  = HTRANS_IDLE;
        cyc = 0; pen = 0; err1 = 0;
        while (HREADYOUT !== 1'b1 && cyc < 20) begin
            if (PENABLE === 1'b1) begin
                pen++;
                if (pen == 4) begin
                    PREADY[1]  = 1'b1;
                    PSLVERR[1] = 1'b1;
                end
            end else if (HRESP === HRESP_ERROR) begin
                err1++;
            end
            @(posedge PCLK); #1;
            cyc++;
        end
        PREADY  = '1;
        PSLVERR = '0;
        mdl_rdata = lane_val[1];
        n_cmp++;
        if ({pen, err1, cyc} !== {32'd4, 32'd1, 32'd6}) begin
            n_bad++;
            $display("FAIL pready_stall: penable/err1/wait cycles got %0d/%0d/%0d want 4/1/6", pen, err1, cyc);
        end
        n_cmp++;
        if ({HREADYOUT, HRESP, PSEL, HRDATA} !== {1'b1, HRESP_ERROR, {NUM_SLV{1'b0}}, mdl_rdata}) begin
            n_bad++;
            $display("FAIL pslverr_resp: hreadyout/hresp/psel/hrdata got %b/%b/%b/%h want 1/01/0/%h",
                     HREADYOUT, HRESP, PSEL, HRDATA, mdl_rdata);
        end
        test_idle(1);
    endtask
`endif

    task automatic test_random(input int n);
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            randomize_lanes();
            addr        = $urandom;
            addr[15:12] = 4'($urandom_range(0, 5));
            do_xfer(1'($urandom_range(0, 1)), addr, $urandom);
            if ($urandom_range(0, 1) != 0) test_idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        randomize_lanes();
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_unmapped();
        test_idle(6);
        test_reset_mid();
`ifdef AHB2APB_PREADY_EN
        test_pready();
`endif
        test_random(150);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
- AHB slave that converts each accepted AHB transfer into one APB transfer.
- Single-clock design; HCLK is PCLK.
- Sits directly upstream of the APB peripherals (GPIO, timers, UART) and drives their PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns their PRDATA to the AHB bus. Non-posted: the AHB data phase completes only after the APB access completes.

Parameters:
- NUM_SLV, 4: number of APB slaves; width of PSEL; number of 32-bit lanes in PRDATA_BUS.
- SLV_SEL_LSB, 12: LSB of the 4-bit slot field HADDR[SLV_SEL_LSB+3:SLV_SEL_LSB].

Ports:
- PCLK  in  1  clock (also the AHB clock)
- PRST_N  in  1  reset, asynchronous, active-low
- HSEL  in  1  bridge selected
- HTRANS  in  2  AHB transfer type
- HWRITE  in  1  write (1) / read (0)
- HADDR  in  32  AHB address
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  bridge ready
- HRESP  out  2  00 = OKAY, 01 = ERROR
- HRDATA  out  32  read data
- PSEL  out  NUM_SLV  one-hot APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PRDATA_BUS  in  32*NUM_SLV  lane k = PRDATA of slave k

Behaviour:
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, state=IDLE.
- Reset asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronous); the transfer is abandoned.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled at a PCLK edge.
  - On accept, register HADDR into PADDR, HWRITE into PWRITE, and the slot field into slot.
  - HTRANS IDLE/BUSY are ignored and get a zero-wait OKAY.
- States: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2. All outputs are registered.
- IDLE / DONE, on accept:
  - slot >= NUM_SLV -> ERR1.
  - Write -> WDATA.
  - Read -> SETUP.
  - No accept -> IDLE.
- WDATA: HREADYOUT=0; capture HWDATA into PWDATA -> SETUP.
- SETUP: PSEL[slot]=1, PENABLE=0, HREADYOUT=0 -> ACCESS.
- ACCESS: PSEL[slot]=1, PENABLE=1, HREADYOUT=0.
  - At the edge ending ACCESS, if the transfer is a read, HRDATA <= lane[slot] of PRDATA_BUS.
  - Next state DONE.
- DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=OKAY. HRDATA is held until the next read completes.
- Latency from the accept edge:
  - Read: SETUP, ACCESS, DONE = 2 wait states.
  - Write: WDATA, SETUP, ACCESS, DONE = 3 wait states.
- Back-to-back: an accept during DONE starts the next transfer with no IDLE cycle, so PSEL deasserts for exactly one cycle between transfers.
- ERR1: HREADYOUT=0, HRESP=ERROR, no APB activity -> ERR2.
- ERR2: HREADYOUT=1, HRESP=ERROR -> IDLE.
  - An accept during ERR2 is treated as in IDLE/DONE.
- PWDATA and PADDR hold their last values while idle. HRESP=OKAY in every state except ERR1/ERR2.

Optional Feature:
- AHB2APB_PREADY_EN defined:
  - Adds inputs PREADY [NUM_SLV] and PSLVERR [NUM_SLV].
  - ACCESS is held while PREADY[slot]=0. The access ends only at an edge where PREADY[slot]=1.
  - If PSLVERR[slot]=1 at that edge, go to ERR1 instead of DONE (HRDATA is still captured).
- Undefined:
  - PREADY is treated as constant 1 and PSLVERR as 0.
  - ACCESS is always exactly one cycle.

Decomposition:
- Package ahb2apb_pkg holds:
  - state enum (IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2);
  - HTRANS codes (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - HRESP codes (OKAY=00, ERROR=01).
- One natural sub-module, ahb2apb_decode: slot -> one-hot PSEL enable plus a NUM_SLV:1 PRDATA lane mux (combinational).

Test Plan:
- Single write: NONSEQ write to 0x0000_1018, HWDATA=0xA5A5_0F0F.
  - PSEL=4'b0010 for 2 cycles; PENABLE high on the 2nd; PADDR=0x0000_1018; PWDATA=0xA5A5_0F0F.
  - HREADYOUT low for 3 cycles, then OKAY.
- Single read: NONSEQ read of 0x0000_0018 with lane0 PRDATA=0x1234_5678.
  - HREADYOUT low for 2 cycles; HRDATA=0x1234_5678 with HREADYOUT=1, HRESP=OKAY.
- Back-to-back: read slot 0, then read slot 2 accepted in DONE.
  - PSEL goes 0001, 0001, 0000, 0100, 0100; both HRDATA values are correct.
- Unmapped address: read of 0x0000_7000 with NUM_SLV=4.
  - HRESP=ERROR for 2 cycles; HREADYOUT 0 then 1; PSEL stays 0.
- Reset mid-transfer: assert PRST_N=0 during ACCESS.
  - PSEL=0, PENABLE=0, HREADYOUT=1 with no clock edge; state IDLE after release.
- With AHB2APB_PREADY_EN: PREADY=0 for 3 cycles, then 1 with PSLVERR=1.
  - PENABLE held for 4 cycles, then a two-cycle ERROR response.
